comms_turn_ctrl: RTL and testbench
==================================

Name: comms_turn_ctrl

Overview:
Sequences the serial board-exchange link for the two-board checkers game. Owns the turn token:
- On the local turn it latches the local board snapshot, waits for the peer to be ready, fires the transfer start and counts outgoing bit clocks to detect completion.
- On the remote turn it counts incoming bit clocks, then captures the received board and flags new data to the Nios PIOs.

It sits between the Nios row/state PIOs and the comms serializer, and replaces the push-button start logic.

Parameters:
- WIDTH, 256, board frame width in bits; also the bit-clock count per transfer.
- TIMEOUT, 50000000, clk cycles allowed in ARM, SEND or RECV before aborting to ERR.
- FIRST_TURN, 1, 1 = local side owns the first move after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- moveReq  in  1  level; local move committed, localBoard valid.
- localBoard  in  WIDTH  board snapshot from the Nios rows.
- readyForSend  in  1  peer ready-to-receive (async; synchronized internally).
- clkOutMon  in  1  comms outgoing bit clock (monitored).
- clkInMon  in  1  comms incoming bit clock (async; synchronized internally).
- receiveBuffer  in  WIDTH  comms deserialized frame.
- errClr  in  1  pulse; leave ERR.
- startTransfer  out  1  one-cycle pulse to comms.
- sendBuffer  out  WIDTH  frame presented to comms.
- remoteBoard  out  WIDTH  last captured peer board.
- newData  out  1  one-cycle pulse on capture.
- myTurn  out  1  local side holds the token.
- sendState  out  2  0 idle, 1 arming, 2 sending, 3 error.
- receiveState  out  2  0 idle, 1 receiving, 2 captured, 3 error.
- moveAck  out  1  one-cycle pulse when localBoard is accepted.

Behaviour:
Reset (rst=0 at a clk edge, which aborts any state):
- State := FIRST_TURN ? IDLE : RECV.
- sendBuffer, remoteBoard := 0.
- startTransfer, newData, moveAck := 0.
- myTurn := FIRST_TURN.
- All counters := 0.
- Synchronizers := 0.

Synchronization:
- readyForSend, clkOutMon and clkInMon each pass through 2 flops.
- A rising edge is detected on sync[1] & ~sync_d. This adds 3 cycles of latency from pin to count.

States:
- IDLE (myTurn=1, sendState=0): on moveReq=1, latch sendBuffer<=localBoard, pulse moveAck, go to ARM.
- ARM (sendState=1): when synced readyForSend=1, pulse startTransfer for exactly 1 cycle, clear bitCnt, go to SEND. The pulse is asserted on the cycle after ARM sees ready.
- SEND (sendState=2): increment bitCnt on each clkOutMon rising edge. When bitCnt reaches WIDTH, myTurn:=0 and go to RECV.
- RECV (myTurn=0, receiveState=1): increment bitCnt on each clkInMon rising edge. At WIDTH, go to CAP.
- CAP (1 cycle): remoteBoard<=receiveBuffer, newData=1, receiveState=2, myTurn:=1, go to IDLE. receiveState holds 2 until the next RECV entry or reset.
- ERR (sendState=3, receiveState=3): outputs frozen, no startTransfer.
  - errClr=1 returns to IDLE if myTurn=1, else RECV.
  - bitCnt and toCnt are cleared on exit.

Timeout and edge rules:
- toCnt counts clk cycles in ARM, SEND and RECV. It resets on every state change and on every counted bit edge.
- toCnt == TIMEOUT-1 → ERR. Timeout has priority over a same-cycle bit edge.
- sendBuffer is stable from moveAck until leaving SEND. A moveReq in any non-IDLE state is ignored; no ack is given.
- Edges beyond WIDTH are ignored (counter saturates; the transition occurs on the WIDTH-th edge).
- clkInMon edges while in SEND are not counted. clkOutMon edges while in RECV are not counted.
- bitCnt width is $clog2(WIDTH+1); toCnt width is $clog2(TIMEOUT).

Decomposition:
- Shared package comms_pkg holds:
  - state enum IDLE, ARM, SEND, RECV, CAP, ERR;
  - sendState/receiveState encodings;
  - default frame WIDTH.
- One sub-module, edge_sync (2-flop synchronizer plus rising-edge pulse), is instantiated three times.

Test Plan:
- Reset with FIRST_TURN=1 → myTurn=1, sendState=0, receiveState=0, sendBuffer=0. Holding rst=0 for 1 cycle mid-SEND returns to IDLE with bitCnt=0.
- moveReq=1 with localBoard=256'h8000…0001 and readyForSend=1 → moveAck pulse, sendBuffer=8000…0001, exactly one startTransfer pulse ≤5 cycles later. 256 clkOutMon edges → myTurn=0, receiveState=1.
- In RECV, drive 256 clkInMon edges with receiveBuffer=256'hA5A5… → 1-cycle newData, remoteBoard=A5A5…, receiveState=2, myTurn=1. 255 edges → no capture.
- TIMEOUT=100, readyForSend=0 after moveReq → ERR on cycle 100 of ARM (sendState=3, no startTransfer). errClr → IDLE.
- In SEND, stop clkOutMon after 10 edges with TIMEOUT=100 → ERR 100 cycles after the last edge. Edges arriving in ERR → no counting, no state change.
- moveReq held high through SEND/RECV → a single moveAck only. A second moveAck appears only after returning to IDLE.

Source files
------------

// File: rtl/comms_pkg.sv
// Shared types and encodings for the checkers board-exchange link controller.
package comms_pkg;

    localparam int unsigned FRAME_WIDTH = 256;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_SEND = 3'd2,
        ST_RECV = 3'd3,
        ST_CAP  = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    localparam logic [1:0] SS_IDLE = 2'd0;
    localparam logic [1:0] SS_ARM  = 2'd1;
    localparam logic [1:0] SS_SEND = 2'd2;
    localparam logic [1:0] SS_ERR  = 2'd3;

    localparam logic [1:0] RS_IDLE = 2'd0;
    localparam logic [1:0] RS_RECV = 2'd1;
    localparam logic [1:0] RS_CAP  = 2'd2;
    localparam logic [1:0] RS_ERR  = 2'd3;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer with a registered-history rising-edge pulse.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], d};
            prev_q <= sync_q[1];
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~prev_q;

endmodule

// File: rtl/comms_turn_ctrl.sv
// Turn-token sequencer for the serial board exchange: send local board, then receive peer board.
module comms_turn_ctrl
    import comms_pkg::*;
#(
    parameter int unsigned WIDTH      = FRAME_WIDTH,
    parameter int unsigned TIMEOUT    = 50000000,
    parameter bit          FIRST_TURN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             moveReq,
    input  logic [WIDTH-1:0] localBoard,
    input  logic             readyForSend,
    input  logic             clkOutMon,
    input  logic             clkInMon,
    input  logic [WIDTH-1:0] receiveBuffer,
    input  logic             errClr,
    output logic             startTransfer,
    output logic [WIDTH-1:0] sendBuffer,
    output logic [WIDTH-1:0] remoteBoard,
    output logic             newData,
    output logic             myTurn,
    output logic [1:0]       sendState,
    output logic [1:0]       receiveState,
    output logic             moveAck
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned TW = $clog2(TIMEOUT);

    state_t           state_q, state_d;
    logic [CW-1:0]    bit_q, bit_d;
    logic [TW-1:0]    to_q, to_d;
    logic             turn_q, turn_d;
    logic [WIDTH-1:0] send_q, send_d;
    logic [WIDTH-1:0] remote_q, remote_d;
    logic             start_q, start_d;
    logic             new_q, new_d;
    logic             ack_q, ack_d;
    logic [1:0]       rs_q, rs_d;

    logic ready_lvl, ready_rise, out_lvl, out_rise, in_lvl, in_rise;
    logic timeout;

    edge_sync u_ready (.clk(clk), .rst(rst), .d(readyForSend), .level(ready_lvl), .rise(ready_rise));
    edge_sync u_out   (.clk(clk), .rst(rst), .d(clkOutMon),    .level(out_lvl),   .rise(out_rise));
    edge_sync u_in    (.clk(clk), .rst(rst), .d(clkInMon),     .level(in_lvl),    .rise(in_rise));

    // Timeout outranks a bit edge arriving in the same cycle.
    assign timeout = (state_q inside {ST_ARM, ST_SEND, ST_RECV}) && (to_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        to_d     = to_q;
        turn_d   = turn_q;
        send_d   = send_q;
        remote_d = remote_q;
        start_d  = 1'b0;
        new_d    = 1'b0;
        ack_d    = 1'b0;
        rs_d     = rs_q;
        unique case (state_q)
            ST_IDLE: if (moveReq) begin
                send_d  = localBoard;
                ack_d   = 1'b1;
                to_d    = '0;
                state_d = ST_ARM;
            end
            ST_ARM: begin
                if (timeout) begin
                    to_d    = '0;
                    state_d = ST_ERR;
                end else if (ready_lvl) begin
                    start_d = 1'b1;
                    bit_d   = '0;
                    to_d    = '0;
                    state_d = ST_SEND;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            ST_SEND: begin
                if (timeout) begin
                    to_d    = '0;
                    state_d = ST_ERR;
                end else if (out_rise) begin
                    to_d = '0;
                    if (bit_q == CW'(WIDTH - 1)) begin
                        bit_d   = '0;
                        turn_d  = 1'b0;
                        rs_d    = RS_RECV;
                        state_d = ST_RECV;
                    end else begin
                        bit_d = bit_q + CW'(1);
                    end
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            ST_RECV: begin
                if (timeout) begin
                    to_d    = '0;
                    state_d = ST_ERR;
                end else if (in_rise) begin
                    to_d = '0;
                    if (bit_q == CW'(WIDTH - 1)) begin
                        bit_d    = '0;
                        remote_d = receiveBuffer;
                        new_d    = 1'b1;
                        rs_d     = RS_CAP;
                        state_d  = ST_CAP;
                    end else begin
                        bit_d = bit_q + CW'(1);
                    end
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            ST_CAP: begin
                turn_d  = 1'b1;
                to_d    = '0;
                state_d = ST_IDLE;
            end
            ST_ERR: if (errClr) begin
                bit_d   = '0;
                to_d    = '0;
                rs_d    = turn_q ? RS_IDLE : RS_RECV;
                state_d = turn_q ? ST_IDLE : ST_RECV;
            end
            default: state_d = ST_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= FIRST_TURN ? ST_IDLE : ST_RECV;
            bit_q    <= '0;
            to_q     <= '0;
            turn_q   <= FIRST_TURN;
            send_q   <= '0;
            remote_q <= '0;
            start_q  <= 1'b0;
            new_q    <= 1'b0;
            ack_q    <= 1'b0;
            rs_q     <= FIRST_TURN ? RS_IDLE : RS_RECV;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            to_q     <= to_d;
            turn_q   <= turn_d;
            send_q   <= send_d;
            remote_q <= remote_d;
            start_q  <= start_d;
            new_q    <= new_d;
            ack_q    <= ack_d;
            rs_q     <= rs_d;
        end
    end

    always_comb begin
        unique case (state_q)
            ST_ARM:  sendState = SS_ARM;
            ST_SEND: sendState = SS_SEND;
            ST_ERR:  sendState = SS_ERR;
            default: sendState = SS_IDLE;
        endcase
        unique case (state_q)
            ST_RECV: receiveState = RS_RECV;
            ST_ERR:  receiveState = RS_ERR;
            default: receiveState = rs_q;
        endcase
    end

    assign startTransfer = start_q;
    assign sendBuffer    = send_q;
    assign remoteBoard   = remote_q;
    assign newData       = new_q;
    assign myTurn        = turn_q;
    assign moveAck       = ack_q;

endmodule

// File: tb/tb_comms_turn_ctrl.sv
// Directed + randomized bench for comms_turn_ctrl, checked against a transaction-level model.
module tb_comms_turn_ctrl;

    localparam int unsigned W  = 256;
    localparam int unsigned TO = 100;

    logic         clk = 1'b0;
    logic         rst, moveReq, readyForSend, clkOutMon, clkInMon, errClr;
    logic [W-1:0] localBoard, receiveBuffer;
    logic         startTransfer, newData, myTurn, moveAck;
    logic [W-1:0] sendBuffer, remoteBoard;
    logic [1:0]   sendState, receiveState;

    int vectors = 0;
    int miscompares = 0;
    int n_ack = 0, n_start = 0, n_new = 0;
    int exp_ack = 0, exp_start = 0, exp_new = 0;
    logic [W-1:0] exp_remote = '0;

    comms_turn_ctrl #(.WIDTH(W), .TIMEOUT(TO), .FIRST_TURN(1'b1)) dut (
        .clk(clk), .rst(rst), .moveReq(moveReq), .localBoard(localBoard),
        .readyForSend(readyForSend), .clkOutMon(clkOutMon), .clkInMon(clkInMon),
        .receiveBuffer(receiveBuffer), .errClr(errClr), .startTransfer(startTransfer),
        .sendBuffer(sendBuffer), .remoteBoard(remoteBoard), .newData(newData),
        .myTurn(myTurn), .sendState(sendState), .receiveState(receiveState), .moveAck(moveAck)
    );

    always #5 clk = ~clk;

    // Pulse monitors: every high cycle counts, so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (moveAck)       n_ack++;
        if (startTransfer) n_start++;
        if (newData)       n_new++;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic out_edge();
        clkOutMon = 1'b1; repeat ($urandom_range(1, 3)) step();
        clkOutMon = 1'b0; repeat ($urandom_range(1, 3)) step();
    endtask

    task automatic in_edge();
        clkInMon = 1'b1; repeat ($urandom_range(1, 3)) step();
        clkInMon = 1'b0; repeat ($urandom_range(1, 3)) step();
    endtask

    // Steps until sendState matches; n is the step count, or -1 when the bound expires.
    task automatic wait_send_state(input logic [1:0] s, input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            step();
            if (sendState === s) begin n = i; break; end
        end
    endtask

    task automatic exchange(input logic [W-1:0] board, input logic [W-1:0] rx);
        int n;
        localBoard = board; moveReq = 1'b1; step(); moveReq = 1'b0;
        exp_ack++;
        check("xchg_ack", W'(n_ack + moveAck), W'(exp_ack));
        check("xchg_sendbuf", sendBuffer, board);
        wait_send_state(2'd2, 10, n);
        check("xchg_reach_send", W'(n > 0), W'(1));
        step();
        exp_start++;
        for (int i = 0; i < W - 1; i++) out_edge();
        repeat (4) step();
        check("xchg_255_out_still_mine", W'(myTurn), W'(1));
        out_edge(); repeat (4) step();
        check("xchg_turn_passed", W'(myTurn), W'(0));
        check("xchg_rs_recv", W'(receiveState), W'(1));
        receiveBuffer = rx;
        for (int i = 0; i < W - 1; i++) in_edge();
        repeat (4) step();
        check("xchg_255_in_no_capture", W'(n_new), W'(exp_new));
        in_edge(); repeat (4) step();
        exp_new++; exp_remote = rx;
        check("xchg_newdata", W'(n_new), W'(exp_new));
        check("xchg_remote", remoteBoard, exp_remote);
        check("xchg_rs_cap", W'(receiveState), W'(2));
        check("xchg_turn_back", W'(myTurn), W'(1));
        check("xchg_start_count", W'(n_start), W'(exp_start));
    endtask

    initial begin
        logic [W-1:0] b1, a5;
        int n;
        b1 = '0; b1[W-1] = 1'b1; b1[0] = 1'b1;
        a5 = {32{8'hA5}};
        rst = 1'b0; moveReq = 1'b0; readyForSend = 1'b0; clkOutMon = 1'b0;
        clkInMon = 1'b0; errClr = 1'b0; localBoard = '0; receiveBuffer = '0;
        repeat (3) step();
        rst = 1'b1; step();
        check("rst_myTurn", W'(myTurn), W'(1));
        check("rst_sendState", W'(sendState), W'(0));
        check("rst_receiveState", W'(receiveState), W'(0));
        check("rst_sendBuffer", sendBuffer, '0);
        check("rst_remoteBoard", remoteBoard, '0);

        // Directed exchange with moveReq held high throughout.
        readyForSend = 1'b1; localBoard = b1; moveReq = 1'b1;
        step(); exp_ack++;
        check("d_ack_seen", W'(moveAck), W'(1));
        check("d_sendbuf", sendBuffer, b1);
        n = -1;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (startTransfer) begin n = i; break; end
        end
        check("d_start_within_5", W'(n > 0), W'(1));
        step(); exp_start++;
        check("d_single_start", W'(n_start), W'(exp_start));
        for (int i = 0; i < W; i++) begin
            out_edge();
            if (i < 5) in_edge();
        end
        repeat (4) step();
        check("d_turn_passed", W'(myTurn), W'(0));
        check("d_rs_recv", W'(receiveState), W'(1));
        check("d_ack_once_held", W'(n_ack), W'(exp_ack));
        receiveBuffer = a5;
        for (int i = 0; i < W - 1; i++) begin
            in_edge();
            if (i < 5) out_edge();
        end
        repeat (4) step();
        check("d_255_no_capture", W'(n_new), W'(0));
        check("d_ack_still_once", W'(n_ack), W'(exp_ack));
        in_edge(); exp_new++; exp_remote = a5;
        repeat (3) step();
        check("d_newdata_once", W'(n_new), W'(exp_new));
        check("d_remote", remoteBoard, exp_remote);
        check("d_rs_cap", W'(receiveState), W'(2));
        // moveReq is still high: back in IDLE it earns a second ack and a new start.
        repeat (6) step(); exp_ack++; exp_start++;
        check("d_second_ack", W'(n_ack), W'(exp_ack));
        check("d_second_start", W'(n_start), W'(exp_start));
        check("d_in_send", W'(sendState), W'(2));
        moveReq = 1'b0;

        // SEND timeout: ten edges, then silence.
        for (int i = 0; i < 9; i++) out_edge();
        clkOutMon = 1'b1;
        wait_send_state(2'd3, 200, n);
        check("send_timeout_cycles", W'(n), W'(103));
        clkOutMon = 1'b0;
        check("err_rs", W'(receiveState), W'(3));
        for (int i = 0; i < 5; i++) begin out_edge(); in_edge(); end
        check("err_frozen_ss", W'(sendState), W'(3));
        check("err_no_start", W'(n_start), W'(exp_start));
        check("err_no_new", W'(n_new), W'(exp_new));
        errClr = 1'b1; step(); errClr = 1'b0; step();
        check("errclr_idle", W'(sendState), W'(0));
        check("errclr_turn", W'(myTurn), W'(1));

        // ARM timeout with the peer never ready.
        readyForSend = 1'b0; repeat (4) step();
        localBoard = {8{$urandom()}}; moveReq = 1'b1; step(); moveReq = 1'b0; exp_ack++;
        check("arm_ack", W'(n_ack + moveAck), W'(exp_ack));
        wait_send_state(2'd3, 200, n);
        check("arm_timeout_cycles", W'(n), W'(100));
        check("arm_no_start", W'(n_start), W'(exp_start));
        errClr = 1'b1; step(); errClr = 1'b0; step();
        check("arm_errclr_idle", W'(sendState), W'(0));
        readyForSend = 1'b1; repeat (4) step();

        // Randomized full exchanges.
        for (int t = 0; t < 3; t++)
            exchange({8{$urandom()}}, {8{$urandom()}});

        // Reset mid-SEND must clear the bit count and the frame.
        localBoard = {8{$urandom()}}; moveReq = 1'b1; step(); moveReq = 1'b0;
        repeat (6) step();
        for (int i = 0; i < 20; i++) out_edge();
        rst = 1'b0; step(); rst = 1'b1; step();
        n_ack = 0; n_start = 0; n_new = 0; exp_ack = 0; exp_start = 0; exp_new = 0;
        check("midrst_ss", W'(sendState), W'(0));
        check("midrst_turn", W'(myTurn), W'(1));
        check("midrst_sendbuf", sendBuffer, '0);
        check("midrst_remote", remoteBoard, '0);
        repeat (4) step();
        exchange({8{$urandom()}}, {8{$urandom()}});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
